// File: rtl/portout_pkg.sv
// Shared types and constants for the portout serializer.
// Build option: define PORTOUT_PARITY_EN to append an even-parity bit to every frame.
package portout_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int unsigned DEF_PAYLOAD_W = 32;
    localparam int unsigned DEF_LSB_FIRST = 1;
    localparam int unsigned DEF_GAP_CYC   = 0;
    localparam int unsigned GAP_W         = 4;

`ifdef PORTOUT_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif

    // Bit counter width able to hold 0..payload_w without wrapping
    function automatic int unsigned cnt_w(input int unsigned payload_w);
        return $clog2(payload_w + 1);
    endfunction

endpackage

// File: rtl/portout_shreg.sv
// Saved payload word and per-bit selection mux for the portout serializer.
// Build option: PORTOUT_PARITY_EN adds the even-parity bit selected at cnt == PAYLOAD_W.
module portout_shreg
    import portout_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int unsigned LSB_FIRST = DEF_LSB_FIRST,
    parameter int unsigned CNT_W     = cnt_w(DEF_PAYLOAD_W)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [PAYLOAD_W-1:0] payload_in,
    input  logic [CNT_W-1:0]     cnt,
    output logic                 data_c
);

    logic [PAYLOAD_W-1:0] saved;
    logic [CNT_W-1:0]     idx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            saved <= '0;
        end else if (load) begin
            saved <= payload_in;
        end
    end

    always_comb begin
        idx = (LSB_FIRST != 0) ? cnt : CNT_W'(PAYLOAD_W - 1) - cnt;
    end

    // Out-of-range indices (parity slot in MSB-first mode) match no bit and yield 0
    always_comb begin
        data_c = 1'b0;
        for (int i = 0; i < int'(PAYLOAD_W); i++) begin
            if (idx == CNT_W'(i)) begin
                data_c = saved[i];
            end
        end
`ifdef PORTOUT_PARITY_EN
        if (cnt == CNT_W'(PAYLOAD_W)) begin
            data_c = ^saved;
        end
`endif
    end

endmodule

// File: rtl/portout_ser.sv
// FIFO-fed serializer: pops one word per frame and shifts it out with active-low framing.
// Build option: PORTOUT_PARITY_EN lengthens each frame by one even-parity bit.
module portout_ser
    import portout_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int unsigned LSB_FIRST = DEF_LSB_FIRST,
    parameter int unsigned GAP_CYC   = DEF_GAP_CYC
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [PAYLOAD_W-1:0] payload_in,
    input  logic                 vld_o,
    input  logic                 hold_i,
    output logic                 pop,
    output logic                 dout,
    output logic                 frameo_n,
    output logic                 valido_n,
    output logic                 busy_o
);

    localparam int unsigned CNT_W = cnt_w(PAYLOAD_W);
    localparam int unsigned LAST  = PAYLOAD_W - 1 + PAR_BITS;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic               pop_nxt, dout_nxt, frame_nxt, valid_nxt, busy_nxt;
    logic               load_c, data_c;

    portout_shreg #(
        .PAYLOAD_W (PAYLOAD_W),
        .LSB_FIRST (LSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_shreg (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (load_c),
        .payload_in (payload_in),
        .cnt        (cnt),
        .data_c     (data_c)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            gap_cnt  <= '0;
            pop      <= 1'b0;
            dout     <= 1'b0;
            frameo_n <= 1'b1;
            valido_n <= 1'b1;
            busy_o   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            gap_cnt  <= gap_nxt;
            pop      <= pop_nxt;
            dout     <= dout_nxt;
            frameo_n <= frame_nxt;
            valido_n <= valid_nxt;
            busy_o   <= busy_nxt;
        end
    end

    // Next state and next registered outputs; a stall holds dout, cnt and frameo_n
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gap_nxt   = gap_cnt;
        pop_nxt   = 1'b0;
        dout_nxt  = dout;
        frame_nxt = frameo_n;
        valid_nxt = 1'b1;
        load_c    = 1'b0;

        case (state)
            IDLE: begin
                frame_nxt = 1'b1;
                if (vld_o) begin
                    load_c    = 1'b1;
                    pop_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!hold_i) begin
                    dout_nxt  = data_c;
                    valid_nxt = 1'b0;
                    if (cnt == CNT_W'(LAST)) begin
                        frame_nxt = 1'b1;
                        gap_nxt   = '0;
                        state_nxt = (GAP_CYC != 0) ? GAP : IDLE;
                    end else begin
                        frame_nxt = 1'b0;
                        cnt_nxt   = cnt + CNT_W'(1);
                    end
                end
            end
            GAP: begin
                frame_nxt = 1'b1;
                if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule
